// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C command sequencer and its FIFOs.
package i2c_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    localparam logic [1:0] SPEED_100K = 2'b00;
    localparam logic [1:0] SPEED_400K = 2'b01;
    localparam logic [1:0] SPEED_1M   = 2'b10;
    localparam logic [1:0] SPEED_3M4  = 2'b11;

    localparam int CMD_W = 16;
    localparam int RSP_W = 10;

    typedef struct packed {
        logic       rw;
        logic [6:0] addr;
        logic [7:0] data;
    } cmd_t;

    typedef struct packed {
        logic [7:0] data;
        logic       ack_err;
        logic       timeout;
    } rsp_t;

endpackage

// File: rtl/i2c_sync_fifo.sv
// Single-clock FIFO; pointers carry an extra wrap bit to tell full from empty.
module i2c_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage is not reset; the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// Queues host byte transactions, drives one at a time into the I2C master with
// a fixed strobe hold, and returns data/ack/timeout status through a response FIFO.
module i2c_cmd_sequencer
    import i2c_pkg::*;
#(
    parameter int         DEPTH         = 8,
    parameter int         START_HOLD    = 200,
    parameter int         TIMEOUT       = 50000,
    parameter logic [1:0] SPEED_DEFAULT = 2'b10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rw,
    input  logic [6:0] cmd_addr,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_ack_err,
    output logic       rsp_timeout,
    output logic       busy,
    output logic       m_write,
    output logic       m_read,
    output logic [1:0] m_speed_mode,
    output logic [6:0] m_addr,
    output logic [7:0] m_data_wr,
    input  logic [7:0] m_data_rd,
    input  logic       m_done,
    input  logic       m_ack_error
);
    localparam int HW = $clog2(START_HOLD + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_e        state, state_nxt;
    cmd_t          cmd_in, cmd_head;
    rsp_t          rsp_in, rsp_head;
    logic          cmd_full, cmd_empty, cmd_pop;
    logic          rsp_full, rsp_empty, rsp_push;
    logic          rw_q, done_q, done_seen, done_rise, timed_out;
    logic          ack_q, to_q;
    logic [7:0]    rd_q;
    logic [HW-1:0] hold_cnt;
    logic [TW-1:0] to_cnt;

    assign cmd_in       = {cmd_rw, cmd_addr, cmd_data};
    assign rsp_in       = {rd_q, ack_q, to_q};
    assign cmd_ready    = !cmd_full;
    assign rsp_valid    = !rsp_empty;
    assign rsp_data     = rsp_head.data;
    assign rsp_ack_err  = rsp_head.ack_err;
    assign rsp_timeout  = rsp_head.timeout;
    assign busy         = (state != IDLE) || !cmd_empty;
    assign m_speed_mode = SPEED_DEFAULT;
    assign done_rise    = m_done && !done_q;
    assign timed_out    = (to_cnt == TW'(TIMEOUT - 1));

    i2c_sync_fifo #(.WIDTH(CMD_W), .DEPTH(DEPTH)) u_cmd_fifo (
        .clk(clk), .rst(rst),
        .push(cmd_valid), .din(cmd_in), .full(cmd_full),
        .pop(cmd_pop), .dout(cmd_head), .empty(cmd_empty)
    );

    i2c_sync_fifo #(.WIDTH(RSP_W), .DEPTH(DEPTH)) u_rsp_fifo (
        .clk(clk), .rst(rst),
        .push(rsp_push), .din(rsp_in), .full(rsp_full),
        .pop(rsp_ready), .dout(rsp_head), .empty(rsp_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cmd_pop   = 1'b0;
        rsp_push  = 1'b0;
        case (state)
            IDLE: if (!cmd_empty && !rsp_full) begin
                cmd_pop   = 1'b1;
                state_nxt = ISSUE;
            end
            ISSUE: if (hold_cnt == HW'(START_HOLD)) state_nxt = WAIT;
            // A done edge seen in ISSUE, or one arriving now, beats the timeout.
            WAIT: if (done_seen || done_rise || timed_out) state_nxt = RESP;
            RESP: begin
                rsp_push  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_write   <= 1'b0;
            m_read    <= 1'b0;
            m_addr    <= '0;
            m_data_wr <= '0;
            rw_q      <= RW_WRITE;
            done_q    <= 1'b0;
            done_seen <= 1'b0;
            hold_cnt  <= '0;
            to_cnt    <= '0;
            rd_q      <= '0;
            ack_q     <= 1'b0;
            to_q      <= 1'b0;
        end else begin
            done_q <= m_done;
            case (state)
                IDLE: if (cmd_pop) begin
                    rw_q      <= cmd_head.rw;
                    m_addr    <= cmd_head.addr;
                    m_data_wr <= (cmd_head.rw == RW_READ) ? 8'h00 : cmd_head.data;
                    hold_cnt  <= '0;
                    to_cnt    <= '0;
                    done_seen <= 1'b0;
                    rd_q      <= '0;
                    ack_q     <= 1'b0;
                    to_q      <= 1'b0;
                end
                ISSUE: begin
                    to_cnt <= to_cnt + TW'(1);
                    if (hold_cnt < HW'(START_HOLD)) begin
                        hold_cnt <= hold_cnt + HW'(1);
                        m_write  <= (rw_q == RW_WRITE);
                        m_read   <= (rw_q == RW_READ);
                    end else begin
                        m_write <= 1'b0;
                        m_read  <= 1'b0;
                    end
                    if (done_rise) begin
                        done_seen <= 1'b1;
                        rd_q      <= (rw_q == RW_READ) ? m_data_rd : 8'h00;
                        ack_q     <= m_ack_error;
                    end
                end
                WAIT: begin
                    to_cnt <= to_cnt + TW'(1);
                    if (!done_seen) begin
                        if (done_rise) begin
                            rd_q  <= (rw_q == RW_READ) ? m_data_rd : 8'h00;
                            ack_q <= m_ack_error;
                        end else if (timed_out) begin
                            to_q <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Scoreboard bench for i2c_cmd_sequencer with a behavioural master + one slave at 0x19.
module tb_i2c_cmd_sequencer;
    localparam int        DEPTH      = 8;
    localparam int        START_HOLD = 200;
    localparam int        TIMEOUT    = 1000;
    localparam int        DONE_DLY   = 300;
    localparam logic [6:0] SLAVE     = 7'h19;

    logic       clk = 1'b0, rst = 1'b1;
    logic       cmd_valid = 1'b0, cmd_rw = 1'b0, rsp_ready = 1'b0;
    logic [6:0] cmd_addr = '0;
    logic [7:0] cmd_data = '0;
    logic       cmd_ready, rsp_valid, rsp_ack_err, rsp_timeout, busy, m_write, m_read;
    logic [7:0] rsp_data, m_data_wr;
    logic [6:0] m_addr;
    logic [1:0] m_speed_mode;
    logic [7:0] m_data_rd = 8'h00;
    logic       m_done = 1'b0, m_ack_error = 1'b0;

    i2c_cmd_sequencer #(.DEPTH(DEPTH), .START_HOLD(START_HOLD), .TIMEOUT(TIMEOUT),
                        .SPEED_DEFAULT(2'b10)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_ack_err(rsp_ack_err), .rsp_timeout(rsp_timeout), .busy(busy),
        .m_write(m_write), .m_read(m_read), .m_speed_mode(m_speed_mode), .m_addr(m_addr),
        .m_data_wr(m_data_wr), .m_data_rd(m_data_rd), .m_done(m_done), .m_ack_error(m_ack_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Master: done pulses DONE_DLY cycles after the strobe is first seen.
    logic       hang = 1'b0, m_active = 1'b0, m_is_rd = 1'b0;
    logic [6:0] m_la = '0;
    logic [7:0] m_ld = '0, slave_reg = 8'h00;
    int         m_cnt = 0, m_txn = 0;
    always @(posedge clk) begin
        if (rst) begin
            m_active <= 1'b0;
            m_done   <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (!m_active) begin
                if (m_write || m_read) begin
                    m_active <= 1'b1;
                    m_cnt    <= 0;
                    m_is_rd  <= m_read;
                    m_la     <= m_addr;
                    m_ld     <= m_data_wr;
                    m_txn    <= m_txn + 1;
                end
            end else begin
                m_cnt <= m_cnt + 1;
                if (m_cnt == DONE_DLY) begin
                    m_active <= 1'b0;
                    if (!hang) begin
                        m_done <= 1'b1;
                        if (m_la == SLAVE) begin
                            m_ack_error <= 1'b0;
                            if (m_is_rd) m_data_rd <= slave_reg;
                            else begin
                                slave_reg <= m_ld;
                                m_data_rd <= 8'hEE;
                            end
                        end else begin
                            m_ack_error <= 1'b1;
                            m_data_rd   <= 8'hEE;
                        end
                    end
                end
            end
        end
    end

    logic       wr_prev = 0, rd_prev = 0, dn_prev = 0, rv_prev = 0;
    int         wr_rise = 0, rd_rise = 0, wr_len = 0, rd_len = 0, done_cyc = 0, rv_cyc = 0;
    logic [6:0] mon_addr = '0;
    logic [7:0] mon_wdata = '0;
    always @(negedge clk) begin
        wr_prev <= m_write; rd_prev <= m_read; dn_prev <= m_done; rv_prev <= rsp_valid;
        if (m_write && !wr_prev) begin
            wr_rise <= cyc; wr_len <= 1; mon_addr <= m_addr; mon_wdata <= m_data_wr;
        end else if (m_write) wr_len <= wr_len + 1;
        if (m_read && !rd_prev) begin
            rd_rise <= cyc; rd_len <= 1; mon_addr <= m_addr; mon_wdata <= m_data_wr;
        end else if (m_read) rd_len <= rd_len + 1;
        if (m_done && !dn_prev) done_cyc <= cyc;
        if (rsp_valid && !rv_prev) rv_cyc <= cyc;
    end

    logic [9:0] sb[$];
    logic [7:0] ref_reg = 8'h00;
    int         pass = 0, total = 0, push_cyc = 0;

    task automatic push_cmd(input logic rw, input logic [6:0] a, input logic [7:0] d);
        int t = 0;
        logic [9:0] exp;
        cmd_valid = 1'b1; cmd_rw = rw; cmd_addr = a; cmd_data = d;
        while (!cmd_ready && t < 1000) begin @(negedge clk); t++; end
        total++;
        if (!cmd_ready) begin
            $display("FAIL push_wait: cmd_ready=0 after %0d cycles, required 1", t);
            cmd_valid = 1'b0;
            return;
        end
        pass++;
        @(negedge clk);
        cmd_valid = 1'b0;
        push_cyc  = cyc;
        if (hang)            exp = {8'h00, 1'b0, 1'b1};
        else if (a != SLAVE) exp = {8'h00, 1'b1, 1'b0};
        else if (rw)         exp = {ref_reg, 2'b00};
        else begin           exp = 10'h000; ref_reg = d; end
        sb.push_back(exp);
    endtask

    task automatic pop_rsp(input string nm);
        int t = 0;
        logic [9:0] exp, got;
        while (!rsp_valid && t < 3000) begin @(negedge clk); t++; end
        total++;
        if (!rsp_valid) begin
            $display("FAIL %s: rsp_valid=0 after %0d cycles, required 1", nm, t);
            return;
        end
        got = {rsp_data, rsp_ack_err, rsp_timeout};
        if (sb.size() == 0) $display("FAIL %s: unexpected response %h, required none", nm, got);
        else begin
            exp = sb.pop_front();
            if (got !== exp) $display("FAIL %s: rsp {data,ack,to}=%h, required %h", nm, got, exp);
            else pass++;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++; if ({m_write, m_read} !== 2'b00) $display("FAIL rst_strobe: %b, required 00", {m_write, m_read}); else pass++;
        total++; if ({m_addr, m_data_wr} !== 15'h0) $display("FAIL rst_addr_data: %h, required 0", {m_addr, m_data_wr}); else pass++;
        total++; if (m_speed_mode !== 2'b10) $display("FAIL rst_speed: %b, required 10", m_speed_mode); else pass++;
        total++; if ({rsp_valid, cmd_ready, busy} !== 3'b010) $display("FAIL rst_flags: %b, required 010", {rsp_valid, cmd_ready, busy}); else pass++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write();
        push_cmd(1'b0, SLAVE, 8'h59);
        pop_rsp("write_rsp");
        total++; if (wr_rise - push_cyc !== 2) $display("FAIL wr_latency: %0d, required 2", wr_rise - push_cyc); else pass++;
        total++; if (wr_len !== START_HOLD) $display("FAIL wr_len: %0d, required %0d", wr_len, START_HOLD); else pass++;
        total++; if ({mon_addr, mon_wdata} !== {SLAVE, 8'h59}) $display("FAIL wr_bus: %h, required %h", {mon_addr, mon_wdata}, {SLAVE, 8'h59}); else pass++;
        total++; if (slave_reg !== 8'h59) $display("FAIL wr_slave: %h, required 59", slave_reg); else pass++;
        total++; if (rv_cyc - done_cyc !== 2) $display("FAIL rsp_latency: %0d, required 2", rv_cyc - done_cyc); else pass++;
    endtask

    task automatic test_read();
        push_cmd(1'b1, SLAVE, 8'hFF);
        pop_rsp("read_rsp");
        total++; if (rd_len !== START_HOLD) $display("FAIL rd_len: %0d, required %0d", rd_len, START_HOLD); else pass++;
        total++; if ({mon_addr, mon_wdata} !== {SLAVE, 8'h00}) $display("FAIL rd_bus: %h, required %h", {mon_addr, mon_wdata}, {SLAVE, 8'h00}); else pass++;
    endtask

    task automatic test_nack();
        push_cmd(1'b0, 7'h7F, 8'h11);
        push_cmd(1'b0, SLAVE, 8'hA5);
        pop_rsp("nack_rsp");
        pop_rsp("after_nack_rsp");
        total++; if (slave_reg !== 8'hA5) $display("FAIL nack_next_slave: %h, required a5", slave_reg); else pass++;
    endtask

    task automatic test_back_to_back();
        int n0 = m_txn;
        for (int i = 0; i < 16; i++) push_cmd(i % 4 == 3, SLAVE, 8'(i * 13 + 5));
        repeat (700) @(negedge clk);
        total++; if (cmd_ready !== 1'b0) $display("FAIL bp_cmd_ready: %b, required 0", cmd_ready); else pass++;
        total++; if ({rsp_valid, busy, m_write, m_read} !== 4'b1100) $display("FAIL bp_stall: %b, required 1100", {rsp_valid, busy, m_write, m_read}); else pass++;
        total++; if (m_txn - n0 !== DEPTH) $display("FAIL bp_issued: %0d, required %0d", m_txn - n0, DEPTH); else pass++;
        fork
            for (int j = 16; j < 20; j++) push_cmd(j % 4 == 3, SLAVE, 8'(j * 13 + 5));
            for (int k = 0; k < 20; k++) pop_rsp("bp_rsp");
        join
        repeat (10) @(negedge clk);
        total++; if ({rsp_valid, busy} !== 2'b00) $display("FAIL bp_drained: %b, required 00", {rsp_valid, busy}); else pass++;
        total++; if (m_txn - n0 !== 20 || sb.size() != 0) $display("FAIL bp_count: txn %0d sb %0d, required 20 0", m_txn - n0, sb.size()); else pass++;
    endtask

    task automatic test_timeout();
        int t = 0;
        hang = 1'b1;
        push_cmd(1'b1, SLAVE, 8'h00);
        while (!rsp_valid && t < 1500) begin @(negedge clk); t++; end
        total++; if ({m_write, m_read} !== 2'b00) $display("FAIL to_strobe: %b, required 00", {m_write, m_read}); else pass++;
        pop_rsp("timeout_rsp");
        total++; if (rv_cyc - rd_rise !== TIMEOUT) $display("FAIL to_latency: %0d, required %0d", rv_cyc - rd_rise, TIMEOUT); else pass++;
        hang = 1'b0;
        repeat (150) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int t = 0;
        logic [7:0] saved = ref_reg;
        push_cmd(1'b0, SLAVE, 8'h77);
        while (!m_write && t < 100) begin @(negedge clk); t++; end
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        ref_reg = saved;
        total++; if ({m_write, rsp_valid, cmd_ready} !== 3'b001) $display("FAIL rst_issue: %b, required 001", {m_write, rsp_valid, cmd_ready}); else pass++;
        push_cmd(1'b1, SLAVE, 8'h00);
        t = 0;
        while (!m_read && t < 100) begin @(negedge clk); t++; end
        t = 0;
        while (m_read && t < 300) begin @(negedge clk); t++; end
        repeat (50) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        total++; if ({m_write, m_read, rsp_valid, cmd_ready, busy} !== 5'b00010) $display("FAIL rst_wait: %b, required 00010", {m_write, m_read, rsp_valid, cmd_ready, busy}); else pass++;
        repeat (400) @(negedge clk);
        total++; if (rsp_valid !== 1'b0) $display("FAIL rst_no_rsp: %b, required 0", rsp_valid); else pass++;
        push_cmd(1'b0, SLAVE, 8'h3C);
        pop_rsp("post_rst_rsp");
        total++; if (slave_reg !== 8'h3C) $display("FAIL post_rst_slave: %h, required 3c", slave_reg); else pass++;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_nack();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, required finished", $time);
        $fatal(1, "watchdog");
    end

endmodule
